// File: rtl/port_io_receiver.sv
// port_io_receiver
// Return-path deserializer for the port I/O link. The remote expander board
// shifts its input-pin states back over three wires (port_clk, port_rst used as
// a frame strobe, data). All three are oversampled in the clk domain, a frame
// of 88 bits (port0..port9 MSB first, then an XOR checksum byte) is collected,
// and the ten port registers are updated together only when the checksum holds.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-low reset
//   port_clk     serial bit clock from the remote board (async to clk)
//   port_rst     frame strobe, high for the whole frame (async to clk)
//   data         serial data, valid at the port_clk rising edge (async to clk)
//   port0..9     last accepted input-port values
//   frame_valid  one-clk pulse when a good frame has updated port0..port9
//   frame_err    one-clk pulse on checksum, short-frame or timeout error
//   link_ok      high after a good frame, low after reset or any error
//   fsm_state    debug view of the receive FSM (0 IDLE, 1 SHIFT, 2 CHECK, 3 WAIT_END)
//
// Interface note: there is no handshake on the output side. frame_valid and
// frame_err are single-cycle qualifiers with no backpressure; port0..port9
// are stable registers that change only in the frame_valid cycle.

module port_io_receiver #(
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       port_clk,
  input  logic       port_rst,
  input  logic       data,
  output logic [7:0] port0,
  output logic [7:0] port1,
  output logic [7:0] port2,
  output logic [7:0] port3,
  output logic [7:0] port4,
  output logic [7:0] port5,
  output logic [7:0] port6,
  output logic [7:0] port7,
  output logic [7:0] port8,
  output logic [7:0] port9,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       link_ok,
  output logic [1:0] fsm_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    CHECK    = 2'd2,
    WAIT_END = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] frm_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   strobe;
  logic                   frm_bit;
  logic                   dat_bit;
  logic [87:0]            shreg;
  logic [6:0]             bcnt;
  logic [TW-1:0]          tcnt;
  logic [7:0]             calc;

  assign fsm_state = state;

  // Equal-depth synchronizers keep the three wires aligned to each other.
  // The strobe and the frame/data bits are registered together, so the FSM
  // sees them one cycle after the edge is detected on the synchronized clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= '0;
      frm_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
      strobe   <= 1'b0;
      frm_bit  <= 1'b0;
      dat_bit  <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], port_clk};
      frm_sync <= {frm_sync[SYNC_STAGES-2:0], port_rst};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      strobe   <= clk_sync[SYNC_STAGES-1] & ~clk_prev;
      frm_bit  <= frm_sync[SYNC_STAGES-1];
      dat_bit  <= dat_sync[SYNC_STAGES-1];
    end
  end

  // Checksum over the ten data bytes; byte k of the frame sits at
  // shreg[8*(10-k) +: 8], the received checksum at shreg[7:0].
  always_comb begin
    calc = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      calc = calc ^ shreg[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bcnt        <= '0;
      tcnt        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      link_ok     <= 1'b0;
      {port0, port1, port2, port3, port4} <= '0;
      {port5, port6, port7, port8, port9} <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          bcnt <= '0;
          tcnt <= '0;
          if (strobe && frm_bit) begin
            shreg <= {shreg[86:0], dat_bit};
            bcnt  <= 7'd1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (strobe) begin
            if (frm_bit) begin
              shreg <= {shreg[86:0], dat_bit};
              tcnt  <= '0;
              if (bcnt >= 7'd87) begin
                // 88th bit: checksum is compared on the next cycle
                bcnt  <= 7'd88;
                state <= CHECK;
              end else begin
                bcnt <= bcnt + 7'd1;
              end
            end else begin
              // frame strobe dropped before all 88 bits arrived
              frame_err <= 1'b1;
              link_ok   <= 1'b0;
              bcnt      <= '0;
              state     <= IDLE;
            end
          end else if (tcnt >= TW'(TIMEOUT - 1)) begin
            // TIMEOUT clk edges since the last accepted bit
            frame_err <= 1'b1;
            link_ok   <= 1'b0;
            bcnt      <= '0;
            tcnt      <= '0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        CHECK: begin
          if (calc == shreg[7:0]) begin
            port0       <= shreg[80 +: 8];
            port1       <= shreg[72 +: 8];
            port2       <= shreg[64 +: 8];
            port3       <= shreg[56 +: 8];
            port4       <= shreg[48 +: 8];
            port5       <= shreg[40 +: 8];
            port6       <= shreg[32 +: 8];
            port7       <= shreg[24 +: 8];
            port8       <= shreg[16 +: 8];
            port9       <= shreg[8 +: 8];
            frame_valid <= 1'b1;
            link_ok     <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            link_ok   <= 1'b0;
          end
          state <= WAIT_END;
        end
        WAIT_END: begin
          // extra strobes are ignored until the frame strobe goes low
          if (!frm_sync[SYNC_STAGES-1]) begin
            bcnt  <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
